ofm_row_writer: RTL
===================

# ofm_row_writer

Output-feature-map write-back stage that sits directly downstream of the SA/E/ReLU/quantify pipeline. It captures each quantized output-channel row vector as it emerges (row-valid, row index, tile-end marker) and buffers it in a small FIFO. It then writes each row into the output feature-map buffer through a valid/ready write port, with addresses derived from a per-tile base and a power-of-two row stride. Back-pressure from the buffer is absorbed without losing rows; protocol violations are flagged in sticky error bits.

## Interface
- LANES, 16, int8 pixels per row vector
- NROW, 16, output-channel rows per tile (legal row index 0..NROW-1)
- DEPTH, 32, FIFO entries (power of two)
- ADDR_W, 16, buffer address width
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- tile_start  in  1  one-cycle pulse; latches cfg_base_addr/cfg_row_shift; accepted only in IDLE
- cfg_base_addr  in  ADDR_W  address of row 0 of this tile
- cfg_row_shift  in  4  row stride = 1 << cfg_row_shift
- q_valid  in  1  quantized row present this cycle
- q_row_idx  in  6  output-channel row index
- q_data  in  LANES*8  quantized row, lane 0 in bits [7:0]
- q_tile_end  in  1  qualifies q_valid: last row of tile
- wr_valid  out  1  write request
- wr_ready  in  1  buffer accepts write
- wr_addr  out  ADDR_W  write address
- wr_data  out  LANES*8  write data
- busy  out  1  state != IDLE
- tile_done  out  1  one-cycle pulse after last row written
- err_ovf  out  1  sticky: row dropped, FIFO full
- err_idx  out  1  sticky: row index >= NROW or out of sequence
- err_idle  out  1  sticky: q_valid seen in IDLE

## Operation
- States: IDLE, ACTIVE, DRAIN.
- IDLE -> ACTIVE on tile_start. Latch base/shift and clear expected_idx to 0.
- ACTIVE -> DRAIN when a row with q_tile_end=1 is pushed.
- DRAIN -> IDLE when the entry marked last completes a wr handshake. tile_done pulses the following cycle.
- tile_start outside IDLE is ignored.
- Push, ACTIVE only: the entry {row_idx, data, last} is pushed when q_valid=1, q_row_idx<NROW, and the FIFO is not full or is popping this cycle.
  - q_row_idx >= NROW: row dropped, err_idx set.
  - q_row_idx != expected_idx: row pushed anyway, err_idx set.
  - expected_idx = pushed idx + 1.
- q_valid in IDLE or DRAIN: dropped. IDLE sets err_idle; DRAIN sets err_idx.
- Full with no pop: row dropped, err_ovf set. If that row carried q_tile_end, the FSM still enters DRAIN and completes on the last FIFO entry. tile_done still pulses.
- Pop: the output register loads from the FIFO when it is non-empty and (wr_valid=0 or wr_ready=1).
  - wr_addr = base + (row_idx << cfg_row_shift), truncated to ADDR_W; wrap-around is permitted.
  - wr_valid, wr_addr and wr_data stay stable while wr_valid=1 and wr_ready=0.
- Error bits clear only on reset.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE
  - FIFO empty
  - expected_idx 0
- Latency: q_valid in cycle t -> wr_valid first high in cycle t+2, given an empty pipeline and wr_ready=1.
- Sustained throughput: one row per cycle with wr_ready held high.
- Push and pop in the same cycle when full: the push is accepted and the count is unchanged.
- Last row's handshake in cycle t -> tile_done=1 and busy=0 in cycle t+1.
- A new tile_start is accepted in that same cycle t+1.
- Reset asserted mid-tile: all state clears asynchronously. Any pending write is discarded and wr_valid drops immediately.

## Structure
- Shared package `ofm_wb_pkg` holds:
  - state enum
  - FIFO entry struct {last, row_idx[5:0], data}
  - LANES/NROW defaults
- One sub-module, `ofm_row_fifo`: synchronous FIFO with DEPTH entries, full/empty flags, and a simultaneous push/pop rule.
- The FSM, address generation, output register and error logic live in the top level.

## Test plan
- Nominal tile: tile_start with base=0x0100 and shift=4, then 16 back-to-back rows idx 0..15 (last on 15), wr_ready=1. Expect:
  - writes at 0x0100, 0x0110 … 0x01F0
  - first wr_valid two cycles after the first q_valid
  - tile_done one cycle after the 16th handshake
  - no errors
- Back-pressure: as the nominal tile, but wr_ready toggles 1/0 every cycle. Expect:
  - all 16 writes in order
  - wr_addr/wr_data held stable during stalls
  - err_ovf=0
- Overflow: wr_ready=0 while 40 rows are pushed (DEPTH=32). Expect:
  - 32 entries stored plus 1 in the output register
  - rows beyond that dropped
  - err_ovf=1
  - after wr_ready=1, exactly 33 writes and then tile_done
- Index errors: row sequence 0,1,3 followed by idx 20. Expect:
  - err_idx=1
  - idx 3 is written at base+(3<<shift)
  - idx 20 is never written
- Idle and reset: a q_valid before tile_start sets err_idle with no write. Asserting reset low during stalled writes gives wr_valid=0 and busy=0 immediately, with all errors cleared.

Source files
------------

// File: rtl/ofm_wb_pkg.sv
// Shared types and defaults for the output-feature-map write-back stage.
//   state_e     : write-back FSM states
//   row_entry_t : one buffered row {last, row_idx, data}
//   DEF_LANES / DEF_NROW : default row width (int8 lanes) and rows per tile
package ofm_wb_pkg;

    localparam int unsigned DEF_LANES = 16;
    localparam int unsigned DEF_NROW  = 16;
    localparam int unsigned IDX_W     = 6;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDrain  = 2'd2
    } state_e;

    typedef struct packed {
        logic                   last;
        logic [IDX_W-1:0]       row_idx;
        logic [DEF_LANES*8-1:0] data;
    } row_entry_t;

endpackage

// File: rtl/ofm_row_fifo.sv
// Synchronous FIFO for buffered output rows.
//   clk, reset  : clock, asynchronous active-low reset
//   push/wdata  : write request and data; ignored when full unless popping the same cycle
//   pop/rdata   : read request (ignored when empty) and head-of-queue data
//   full, empty : occupancy flags
module ofm_row_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ofm_row_writer.sv
// Output-feature-map row write-back stage.
//   clk, reset                  : clock, asynchronous active-low reset
//   tile_start, cfg_base_addr,
//   cfg_row_shift               : start a tile; base address of row 0 and log2 row stride
//   q_valid, q_row_idx, q_data,
//   q_tile_end                  : quantized row stream from the quantify stage
//   wr_valid, wr_ready, wr_addr,
//   wr_data                     : valid/ready write port into the output buffer
//   busy, tile_done             : tile in progress / one-cycle completion pulse
//   err_ovf, err_idx, err_idle  : sticky protocol error flags
module ofm_row_writer
    import ofm_wb_pkg::*;
#(
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned NROW   = DEF_NROW,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tile_start,
    input  logic [ADDR_W-1:0]  cfg_base_addr,
    input  logic [3:0]         cfg_row_shift,
    input  logic               q_valid,
    input  logic [5:0]         q_row_idx,
    input  logic [LANES*8-1:0] q_data,
    input  logic               q_tile_end,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [LANES*8-1:0] wr_data,
    output logic               busy,
    output logic               tile_done,
    output logic               err_ovf,
    output logic               err_idx,
    output logic               err_idle
);

    state_e            state;
    logic [ADDR_W-1:0] base;
    logic [3:0]        shift;
    logic [5:0]        exp_idx;
    logic              drop_last;  // tile-end row was lost to overflow
    logic              wr_last;

    row_entry_t        f_in;
    row_entry_t        f_out;
    logic              f_push;
    logic              f_pop;
    logic              f_full;
    logic              f_empty;
    logic              idx_ok;
    logic              ovf_drop;
    logic              hs;
    logic              done_hs;

    assign idx_ok   = (32'(q_row_idx) < NROW);
    assign f_pop    = !f_empty && (!wr_valid || wr_ready);
    assign f_push   = (state == StActive) && q_valid && idx_ok && (!f_full || f_pop);
    assign ovf_drop = (state == StActive) && q_valid && idx_ok && f_full && !f_pop;
    assign hs       = wr_valid && wr_ready;
    // Without a marked entry, the tile ends when the final outstanding row leaves.
    assign done_hs  = (state == StDrain) && hs && (wr_last || (drop_last && f_empty));
    assign busy     = (state != StIdle);

    assign f_in = '{last: q_tile_end, row_idx: q_row_idx, data: q_data};

    ofm_row_fifo #(
        .WIDTH ($bits(row_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (f_push),
        .wdata (f_in),
        .pop   (f_pop),
        .rdata (f_out),
        .full  (f_full),
        .empty (f_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            base      <= '0;
            shift     <= '0;
            exp_idx   <= '0;
            drop_last <= 1'b0;
            tile_done <= 1'b0;
            err_ovf   <= 1'b0;
            err_idx   <= 1'b0;
            err_idle  <= 1'b0;
        end else begin
            tile_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (q_valid) begin
                        err_idle <= 1'b1;
                    end
                    if (tile_start) begin
                        state     <= StActive;
                        base      <= cfg_base_addr;
                        shift     <= cfg_row_shift;
                        exp_idx   <= '0;
                        drop_last <= 1'b0;
                    end
                end
                StActive: begin
                    if (q_valid) begin
                        if (!idx_ok || (q_row_idx != exp_idx)) begin
                            err_idx <= 1'b1;
                        end
                        if (ovf_drop) begin
                            err_ovf <= 1'b1;
                        end
                        if (f_push) begin
                            exp_idx <= q_row_idx + 6'd1;
                        end
                        if (q_tile_end && (f_push || ovf_drop)) begin
                            state     <= StDrain;
                            drop_last <= ovf_drop;
                        end
                    end
                end
                StDrain: begin
                    if (q_valid) begin
                        err_idx <= 1'b1;
                    end
                    if (done_hs) begin
                        state     <= StIdle;
                        tile_done <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Output register: reloads only when empty or its current write is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_last  <= 1'b0;
        end else if (f_pop) begin
            wr_valid <= 1'b1;
            wr_addr  <= base + ({{(ADDR_W-6){1'b0}}, f_out.row_idx} << shift);
            wr_data  <= f_out.data;
            wr_last  <= f_out.last;
        end else if (hs) begin
            wr_valid <= 1'b0;
        end
    end

endmodule
